// File: rtl/shift_pkg.sv
// Shared definitions for the shift controller: datapath width,
// operation codes, controller states and a 32-bit bit-reverse helper.
package shift_pkg;

    localparam int N = 32;

    typedef enum logic [1:0] {
        OP_SLL = 2'b00,
        OP_SRL = 2'b01,
        OP_SRA = 2'b10,
        OP_ILL = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_MASK  = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    function automatic logic [N-1:0] bit_rev(input logic [N-1:0] x);
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) begin
            r[i] = x[N-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/shift_controller_left_shifter.sv
// LeftShifter: combinational 32-bit left barrel shifter.
// Ports: amount (0..31), data (operand), out (data shifted left, zero fill).
module LeftShifter
    import shift_pkg::*;
(
    input  logic [4:0]   amount,
    input  logic [N-1:0] data,
    output logic [N-1:0] out
);

    // Five log-stages: stage k shifts by 2**k when amount[k] is set.
    logic [N-1:0] stage [0:5];

    always_comb begin
        stage[0] = data;
        for (int k = 0; k < 5; k++) begin
            stage[k+1] = amount[k] ? (stage[k] << (1 << k)) : stage[k];
        end
        out = stage[5];
    end

endmodule

// File: rtl/shift_controller.sv
// shift_controller: multi-cycle SLL/SRL/SRA unit built on one left shifter.
// Ports: clk, reset (sync, active-high); in_valid/in_ready/in_op/in_amount/
//        in_data request side; out_valid/out_ready/out_data/out_err result side.
module shift_controller #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [1:0]   in_op,
    input  logic [4:0]   in_amount,
    input  logic [N-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_data,
    output logic         out_err
);
    import shift_pkg::*;

    state_e       state_q, state_d;
    op_e          op_q, op_d;
    logic [4:0]   amt_q, amt_d;
    logic [N-1:0] data_q, data_d;
    logic         sign_q, sign_d;
    logic [N-1:0] part_q, part_d;
    logic [N-1:0] res_q, res_d;
    logic         err_q, err_d;
    logic         in_ready_q, in_ready_d;
    logic         out_valid_q, out_valid_d;

    logic [N-1:0] sh_data;
    logic [N-1:0] sh_out;

    // SHIFT feeds the operand; MASK feeds all-ones so that the reversed,
    // inverted output marks the vacated top bits for sign fill.
    assign sh_data = (state_q == S_MASK) ? '1 : data_q;

    LeftShifter u_shifter (
        .amount (amt_q),
        .data   (sh_data),
        .out    (sh_out)
    );

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        amt_d   = amt_q;
        data_d  = data_q;
        sign_d  = sign_q;
        part_d  = part_q;
        res_d   = res_q;
        err_d   = err_q;

        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    op_d   = op_e'(in_op);
                    amt_d  = in_amount;
                    sign_d = in_data[N-1];
                    // Right shifts become left shifts of the reversed word.
                    if (in_op == OP_SRL || in_op == OP_SRA) begin
                        data_d = bit_rev(in_data);
                    end else begin
                        data_d = in_data;
                    end
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                part_d  = sh_out;
                state_d = S_MASK;
            end
            S_MASK: begin
                err_d = 1'b0;
                unique case (op_q)
                    OP_SLL: res_d = part_q;
                    OP_SRL: res_d = bit_rev(part_q);
                    OP_SRA: res_d = bit_rev(part_q)
                                  | (sign_q ? ~bit_rev(sh_out) : '0);
                    OP_ILL: begin
                        res_d = data_q;
                        err_d = 1'b1;
                    end
                endcase
                state_d = S_DONE;
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
        endcase

        in_ready_d  = (state_d == S_IDLE);
        out_valid_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            op_q        <= OP_SLL;
            amt_q       <= '0;
            data_q      <= '0;
            sign_q      <= 1'b0;
            part_q      <= '0;
            res_q       <= '0;
            err_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            amt_q       <= amt_d;
            data_q      <= data_d;
            sign_q      <= sign_d;
            part_q      <= part_d;
            res_q       <= res_d;
            err_q       <= err_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = res_q;
    assign out_err   = err_q;

endmodule

// File: tb/tb_shift_controller.sv
// Self-checking bench for shift_controller: behavioural reference model,
// per-cycle compare process, directed literal cases and random regression.
module tb_shift_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_op;
    logic [4:0]  in_amount;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_err;

    always #5 clk = ~clk;

    shift_controller #(.N(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_amount (in_amount),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_err   (out_err)
    );

    int checks = 0;
    int passed = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference result: {err, data}
    function automatic logic [32:0] ref_fn(input logic [1:0] op,
                                           input logic [4:0] amt,
                                           input logic [31:0] d);
        logic [31:0] r;
        case (op)
            2'b00:   return {1'b0, d << amt};
            2'b01:   return {1'b0, d >> amt};
            2'b10: begin
                r = $signed(d) >>> amt;
                return {1'b0, r};
            end
            default: return {1'b1, d};
        endcase
    endfunction

    // Model: cycles since accept (0 idle, 3 result shown), last result.
    int          m_stage = 0;
    logic [31:0] m_last;
    logic        m_err;
    logic [32:0] m_pend;
    int          m_accepts = 0;

    always @(posedge clk) begin
        if (reset) begin
            m_stage <= 0;
            m_last  <= 32'h0;
            m_err   <= 1'b0;
        end else begin
            case (m_stage)
                0: if (in_valid) begin
                    m_stage   <= 1;
                    m_pend    <= ref_fn(in_op, in_amount, in_data);
                    m_accepts <= m_accepts + 1;
                end
                1: m_stage <= 2;
                2: begin
                    m_stage <= 3;
                    m_err   <= m_pend[32];
                    m_last  <= m_pend[31:0];
                end
                default: if (out_ready) m_stage <= 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model in_ready", in_ready, (m_stage == 0));
            chk("model out_valid", out_valid, (m_stage == 3));
            chk("model out_data", out_data, m_last);
            chk("model out_err", out_err, m_err);
        end
    end

    // Entered and left just after a falling edge.
    task automatic do_req(input logic [1:0] op, input logic [4:0] amt,
                          input logic [31:0] d, input logic [31:0] exp_d,
                          input logic exp_e, input string name);
        int lat;
        int guard;
        guard = 0;
        while (m_stage != 0 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        in_valid  = 1'b1;
        in_op     = op;
        in_amount = amt;
        in_data   = d;
        out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid  = 1'b0;
        in_data   = $urandom;
        in_op     = 2'($urandom);
        in_amount = 5'($urandom);
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk({name, " latency"}, lat, 3);
        chk({name, " data"}, out_data, exp_d);
        chk({name, " err"}, out_err, exp_e);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        int lat;
        int start;
        int cyc;
        reset     = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        in_op     = 2'b00;
        in_amount = 5'd3;
        in_data   = 32'hCAFE0001;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset    = 1'b0;
        in_valid = 1'b0;
        chk_en   = 1'b1;
        chk("reset in_ready", in_ready, 1);
        chk("reset out_valid", out_valid, 0);
        chk("reset out_data", out_data, 0);
        chk("reset out_err", out_err, 0);

        do_req(2'b00, 5'd31, 32'h00000001, 32'h80000000, 1'b0, "sll31");
        do_req(2'b01, 5'd4,  32'h80000000, 32'h08000000, 1'b0, "srl4");
        do_req(2'b10, 5'd4,  32'h80000000, 32'hF8000000, 1'b0, "sra4");
        do_req(2'b10, 5'd31, 32'h7FFFFFFF, 32'h00000000, 1'b0, "sra31p");
        do_req(2'b10, 5'd31, 32'h80000000, 32'hFFFFFFFF, 1'b0, "sra31n");
        do_req(2'b10, 5'd0,  32'h12345678, 32'h12345678, 1'b0, "sra0");
        do_req(2'b01, 5'd0,  32'h87654321, 32'h87654321, 1'b0, "srl0");
        do_req(2'b11, 5'd7,  32'hDEADBEEF, 32'hDEADBEEF, 1'b1, "illegal");

        // Backpressure with a waiting request.
        in_valid  = 1'b1;
        in_op     = 2'b00;
        in_amount = 5'd4;
        in_data   = 32'h0000000F;
        out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_amount = 5'd1;
        in_data   = 32'h00000003;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("bp latency", lat, 3);
        for (int i = 0; i < 5; i++) begin
            chk("bp hold data", out_data, 32'h000000F0);
            chk("bp in_ready", in_ready, 0);
            chk("bp out_valid", out_valid, 1);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp idle in_ready", in_ready, 1);
        chk("bp idle out_valid", out_valid, 0);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp accepted", in_ready, 0);
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("bp2 latency", lat, 3);
        chk("bp2 data", out_data, 32'h00000006);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;

        // Reset while in MASK.
        in_valid  = 1'b1;
        in_op     = 2'b10;
        in_amount = 5'd3;
        in_data   = 32'h80000000;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("rst mask out_valid", out_valid, 0);
        chk("rst mask in_ready", in_ready, 1);
        chk("rst mask out_data", out_data, 0);
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("rst no stale", out_valid, 0);
        end
        out_ready = 1'b0;

        // Random regression.
        start = m_accepts;
        cyc = 0;
        while (m_accepts - start < 1000 && cyc < 30000) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            in_op     = 2'($urandom_range(0, 3));
            in_amount = 5'($urandom);
            case ($urandom_range(0, 3))
                0: in_data = 32'h80000000 | $urandom;
                1: in_data = 32'h7FFFFFFF & $urandom;
                default: in_data = $urandom;
            endcase
            @(negedge clk);
            cyc++;
        end
        chk("random count", (m_accepts - start >= 1000), 1);

        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (6) @(negedge clk);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/shift_controller.md
SHIFT_CONTROLLER -- requirements
Module: shift_controller

Interface
REQ-001 The block SHALL have parameter: N, 32, datapath width (only 32 is supported).
REQ-002 The block SHALL have port: clk  input  1  single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 The block SHALL have port: in_valid  input  1  request present.
REQ-005 The block SHALL have port: in_ready  output  1  controller can accept a request.
REQ-006 The block SHALL have port: in_op  input  2  operation: 00 SLL, 01 SRL, 10 SRA, 11 illegal.
REQ-007 The block SHALL have port: in_amount  input  5  shift amount 0..31.
REQ-008 The block SHALL have port: in_data  input  N  operand.
REQ-009 The block SHALL have port: out_valid  output  1  result present.
REQ-010 The block SHALL have port: out_ready  input  1  consumer takes the result.
REQ-011 The block SHALL have port: out_data  output  N  shift result.
REQ-012 The block SHALL have port: out_err  output  1  result came from an illegal op; qualified by out_valid.

Function
REQ-013 States SHALL be IDLE, SHIFT, MASK, DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-014 Accept = in_valid & in_ready; on accept: capture op and amount; capture data, bit-reversed when op is SRL/SRA; go to SHIFT.
REQ-015 In SHIFT the single left shifter SHALL take the captured data and amount, the output SHALL be latched as the partial result, and the FSM SHALL go to MASK.
REQ-016 In MASK the same shifter SHALL take all-ones and the amount, the FSM SHALL go to DONE, and the final result SHALL be registered as follows:
- SLL: partial.
- SRL: reverse(partial).
- SRA: reverse(partial) | (sign ? ~reverse(shifter_out) : 0), where sign = bit 31 of the original operand.
REQ-017 Latency SHALL be fixed at 3 cycles for every op and every amount including 0: accept at edge T gives out_valid high after edge T+2.
REQ-018 An illegal op (11) SHALL return out_data = original operand and out_err = 1, with the same 3-cycle latency; all legal ops SHALL return out_err = 0.
REQ-019 In DONE, out_valid & out_ready SHALL return the FSM to IDLE on the next edge; a new request is accepted no earlier than the following cycle.
REQ-020 While in DONE with out_ready low, out_data and out_err SHALL hold stable indefinitely.
REQ-021 in_valid outside IDLE SHALL be ignored without side effects.
REQ-022 In-flight input changes SHALL NOT affect the result; only captured values are used.
REQ-023 The shifter instance SHALL be used by no logic other than the SHIFT and MASK states; its input is don't-care in IDLE and DONE.

Reset
REQ-024 reset high at an edge SHALL force IDLE from any state, discarding any in-flight operation, regardless of in_valid and out_ready.
REQ-025 After reset: out_valid=0, in_ready=1, out_data=0, out_err=0, and all capture registers =0.
REQ-026 A request presented while reset is high SHALL NOT be accepted.

Structure
REQ-027 Shared package shift_pkg SHALL hold: N=32, op encodings, the state enum, and a 32-bit bit-reverse function.
REQ-028 Exactly one sub-module SHALL be instantiated: the team's 32-bit left barrel shifter LeftShifter (amount, data, out), time-multiplexed between SHIFT and MASK.
REQ-029 The design SHALL contain no other shifter, no right-shift operator, and no latches.

Verification
REQ-030 The bench SHALL cover SLL: data=0x00000001, amt=31 -> out_data=0x80000000, out_err=0, out_valid 3 cycles after accept.
REQ-031 The bench SHALL cover SRL and SRA:
- SRL 0x80000000 amt 4 -> 0x08000000.
- SRA 0x80000000 amt 4 -> 0xF8000000.
- SRA 0x7FFFFFFF amt 31 -> 0x00000000.
- SRA 0x80000000 amt 31 -> 0xFFFFFFFF.
- SRA 0x12345678 amt 0 -> 0x12345678.
REQ-032 The bench SHALL cover the illegal op: op=11, data=0xDEADBEEF -> out_data=0xDEADBEEF, out_err=1, latency 3.
REQ-033 The bench SHALL cover backpressure: hold out_ready=0 for 5 cycles in DONE with in_valid=1 and a different in_data -> out_data stable, in_ready=0, no new accept; then out_ready=1 -> IDLE next cycle and the waiting request is accepted one cycle later.
REQ-034 The bench SHALL cover reset during MASK: assert reset for 1 cycle -> next cycle IDLE, out_valid=0, in_ready=1, out_data=0; no stale result appears afterwards.
REQ-035 The bench SHALL cover random regression: 1000 random op/amount/data requests with random out_ready -> every result matches a reference model (SLL <<, SRL logical >>, SRA arithmetic >>).
